// File: rtl/button_pkg.sv
// Shared types and constants for the front-panel button controller.
package button_pkg;

  // Per-channel hold state machine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

  // Bit positions of each event inside a channel's 3-bit status field.
  localparam int ST_PRESS = 2;
  localparam int ST_LONG  = 1;
  localparam int ST_REL   = 0;

  // Hold counter must be able to represent LONG_TICKS itself.
  function automatic int hold_cnt_w(input int long_ticks);
    return $clog2(long_ticks + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, strobe-driven debounce,
// hold-time FSM and single-cycle press / long / release event pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int DEB_CNT     = 4,
  parameter int SHORT_TICKS = 8,
  parameter int LONG_TICKS  = 32,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic SlowClock,
  input  logic MainReset,
  input  logic strobe_16ms,
  input  logic strobe_125ms,
  input  logic button_in,
  output logic debounced,
  output logic press_evt,
  output logic long_evt,
  output logic long_strobe,
  output logic release_evt
);

  localparam int              HW      = hold_cnt_w(LONG_TICKS);
  localparam logic            INACT   = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [3:0]      DEB_TGT = 4'(DEB_CNT);
  localparam logic [HW-1:0]   SHORT_V = HW'(SHORT_TICKS);
  localparam logic [HW-1:0]   LONG_V  = HW'(LONG_TICKS);
  localparam logic [HW-1:0]   CNT_MAX = '1;

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [3:0]    dcnt_q, dcnt_d;
  hold_state_t   state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic          press_q, press_d;
  logic          long_q, long_d;
  logic          rel_q, rel_d;
  logic          pressed;

  // Shift the raw level through the two synchroniser stages.
  always_comb begin
    sync_d = {sync_q[0], button_in};
  end

  // Debounce: count consecutive differing samples, toggle on the DEB_CNT-th.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (strobe_16ms) begin
      if (sync_q[1] != deb_q) begin
        if (dcnt_q + 4'd1 == DEB_TGT) begin
          deb_d  = ~deb_q;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end else begin
        dcnt_d = '0;
      end
    end
  end

  // The FSM looks at the registered debounced level, so a release landing
  // on a coincident strobe is seen one cycle later.
  assign pressed = (deb_q != INACT);

  // Hold FSM: counts 125 ms ticks while pressed and emits event pulses.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    press_d  = 1'b0;
    long_d   = 1'b0;
    rel_d    = 1'b0;
    hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + HW'(1);
    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = HELD;
          hcnt_d  = '0;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else if (strobe_125ms) begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == SHORT_V) press_d = 1'b1;
          if (hcnt_inc == LONG_V) begin
            long_d  = 1'b1;
            state_d = LONG;
          end
        end
      end
      LONG: begin
        if (!pressed) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset returns to the idle, released condition.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset) begin
      sync_q  <= {2{INACT}};
      deb_q   <= INACT;
      dcnt_q  <= '0;
      state_q <= IDLE;
      hcnt_q  <= '0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      press_q <= press_d;
      long_q  <= long_d;
      rel_q   <= rel_d;
    end
  end

  assign debounced   = deb_q;
  assign press_evt   = press_q;
  assign long_evt    = long_q;
  assign release_evt = rel_q;
  assign long_strobe = (state_q == LONG);

endmodule

// File: rtl/button_array_ctrl.sv
// Multi-channel front-panel button controller: NUM_BTN independent channels,
// sticky W1C status with set-wins priority and a masked, registered Irq.
module button_array_ctrl
  import button_pkg::*;
#(
  parameter int NUM_BTN     = 2,
  parameter int DEB_CNT     = 4,
  parameter int SHORT_TICKS = 8,
  parameter int LONG_TICKS  = 32,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                 SlowClock,
  input  logic                 MainReset,
  input  logic                 Strobe16ms,
  input  logic                 Strobe125ms,
  input  logic [NUM_BTN-1:0]   ButtonIn,
  input  logic [NUM_BTN-1:0]   IntMask,
  input  logic [3*NUM_BTN-1:0] IntClear,
  output logic [NUM_BTN-1:0]   Debounced,
  output logic [NUM_BTN-1:0]   PressEvt,
  output logic [NUM_BTN-1:0]   LongEvt,
  output logic [NUM_BTN-1:0]   LongStrobe,
  output logic [NUM_BTN-1:0]   ReleaseEvt,
  output logic [3*NUM_BTN-1:0] IntStatus,
  output logic                 Irq
);

  logic [3*NUM_BTN-1:0] status_q, status_d;
  logic [3*NUM_BTN-1:0] evt_set, unmask;
  logic                 irq_q, irq_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .DEB_CNT    (DEB_CNT),
      .SHORT_TICKS(SHORT_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .SlowClock   (SlowClock),
      .MainReset   (MainReset),
      .strobe_16ms (Strobe16ms),
      .strobe_125ms(Strobe125ms),
      .button_in   (ButtonIn[i]),
      .debounced   (Debounced[i]),
      .press_evt   (PressEvt[i]),
      .long_evt    (LongEvt[i]),
      .long_strobe (LongStrobe[i]),
      .release_evt (ReleaseEvt[i])
    );
  end

  // Status update (event set beats same-cycle clear) and masked interrupt.
  always_comb begin
    evt_set = '0;
    unmask  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      evt_set[3*i+ST_PRESS] = PressEvt[i];
      evt_set[3*i+ST_LONG]  = LongEvt[i];
      evt_set[3*i+ST_REL]   = ReleaseEvt[i];
      unmask[3*i +: 3]      = {3{~IntMask[i]}};
    end
    status_d = evt_set | (status_q & ~IntClear);
    irq_d    = |(status_q & unmask);
  end

  // Status and interrupt registers.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign IntStatus = status_q;
  assign Irq       = irq_q;

endmodule

// File: doc/button_array_ctrl.md
# button_array_ctrl

Parametrised multi-channel front-panel button controller for the ODS-MR CPLD control tree. It debounces NUM_BTN raw button inputs, measures hold time per channel, and produces press, long-press and release events as single-cycle pulses, sticky write-1-to-clear status and a masked aggregate interrupt. It generalises the fixed power/reset button pair to any channel count with programmable debounce and hold thresholds. All logic runs on SlowClock, and the 16 ms and 125 ms strobes are used only as clock enables.

## Interface
- NUM_BTN, 2, number of button channels
- DEB_CNT, 4, consecutive equal Strobe16ms samples needed to change debounced state (1..15)
- SHORT_TICKS, 8, Strobe125ms ticks held before PressEvt (1 s)
- LONG_TICKS, 32, Strobe125ms ticks held before LongEvt (4 s); must be > SHORT_TICKS
- ACTIVE_LOW, 1, 1 means a button reads 0 when pressed
- SlowClock  in  1  32,768 Hz clock
- MainReset  in  1  reset, asynchronous, active-low
- Strobe16ms  in  1  one-SlowClock pulse every 16 ms
- Strobe125ms  in  1  one-SlowClock pulse every 125 ms
- ButtonIn  in  NUM_BTN  raw asynchronous button levels
- IntMask  in  NUM_BTN  1 excludes the channel from Irq
- IntClear  in  3*NUM_BTN  write-1-to-clear pulses, same layout as IntStatus
- Debounced  out  NUM_BTN  debounced level, input polarity
- PressEvt  out  NUM_BTN  1-cycle pulse when hold reaches SHORT_TICKS
- LongEvt  out  NUM_BTN  1-cycle pulse when hold reaches LONG_TICKS
- LongStrobe  out  NUM_BTN  level, high from LongEvt until debounced release
- ReleaseEvt  out  NUM_BTN  1-cycle pulse on every debounced release
- IntStatus  out  3*NUM_BTN  sticky; bits [3i+2:3i] = {Press, Long, Release} of channel i
- Irq  out  1  OR of IntStatus bits of unmasked channels

## Operation
- Input path: 2-flop synchroniser per channel. Reset value is the inactive level (ACTIVE_LOW ? 1 : 0).
- Debounce: 4-bit counter per channel. On Strobe16ms, if the synced input differs from Debounced, the counter increments; otherwise it clears. When the counter reaches DEB_CNT, Debounced toggles and the counter clears. Between strobes the counter holds.
- Hold FSM per channel, states IDLE, HELD, LONG.
  - IDLE -> HELD on Debounced going to pressed. The hold counter clears.
  - HELD: the counter increments on Strobe125ms. At count == SHORT_TICKS, PressEvt pulses. At count == LONG_TICKS, LongEvt pulses and the FSM goes to LONG.
  - HELD or LONG -> IDLE on Debounced release, with a ReleaseEvt pulse.
  - The hold counter is $clog2(LONG_TICKS+1) bits wide and saturates; it never wraps.
- Release before SHORT_TICKS gives ReleaseEvt only. Release between SHORT_TICKS and LONG_TICKS gives PressEvt then ReleaseEvt, with no LongEvt.
- Status: each event pulse sets its IntStatus bit, and IntClear clears it. If set and clear hit the same bit in the same cycle, set wins.
- Irq = |(IntStatus & ~{3{mask}} per channel), registered.
- Reset values: Debounced = inactive level. All event pulses, LongStrobe, IntStatus and Irq = 0. FSM = IDLE, counters = 0.
- Asserting MainReset mid-hold returns the channel to IDLE with no ReleaseEvt. A button still held after reset needs a fresh debounce, then restarts the hold count from 0.

## Timing
- Synchroniser latency: 2 SlowClock cycles.
- Debounce latency: Debounced changes in the cycle of the DEB_CNT-th consecutive differing Strobe16ms sample, i.e. 48–64 ms for DEB_CNT=4.
- Press timing: PressEvt is asserted (SHORT_TICKS-1)..SHORT_TICKS × 125 ms after the debounced press, because the first tick is partial. LongEvt follows the same rule with LONG_TICKS.
- Event outputs are registered and high for exactly one SlowClock cycle.
- IntStatus updates one cycle after the event pulse. Irq follows one cycle after that.
- If Strobe16ms and Strobe125ms coincide, the hold FSM uses the pre-update Debounced. A release on that cycle takes effect on the next cycle.
- Channels are fully independent. Simultaneous events on several channels are all captured.

## Structure
- Package button_pkg holds:
  - hold-FSM state typedef (IDLE=2'd0, HELD=2'd1, LONG=2'd2);
  - status bit offsets (ST_PRESS=2, ST_LONG=1, ST_REL=0);
  - the width function for the hold counter.
- Sub-module button_channel contains the synchroniser, debounce, hold FSM and event pulses for one channel.
- The top level instantiates NUM_BTN button_channel in a generate loop and owns the status register, mask and Irq.

## Test plan
All scenarios use defaults (NUM_BTN=2, DEB_CNT=4, SHORT=8, LONG=32, ACTIVE_LOW=1).
- Bounce rejection: toggle ButtonIn[0] every 20 ms for 200 ms, then hold 1 -> Debounced[0] stays 1; no events; IntStatus = 0.
- Short press: hold ButtonIn[0]=0 for 500 ms -> Debounced[0] falls within 64 ms; ReleaseEvt[0] pulses once; no PressEvt; IntStatus[0]=1; Irq=1.
- Long press: hold ButtonIn[1]=0 for 5 s -> PressEvt[1] at ~1 s, then LongEvt[1] and LongStrobe[1] rise at ~4 s; on release, LongStrobe[1] falls and ReleaseEvt[1] pulses; IntStatus[5:3]=3'b111.
- W1C race: drive IntClear[2]=1 in the same cycle as a PressEvt[0] -> IntStatus[2] stays 1. Drive IntClear=6'h3F while idle -> IntStatus=0 and Irq=0 one cycle later.
- Masking: set IntMask=2'b01 and long-press channel 0 -> IntStatus set, Irq=0. Clear the mask -> Irq=1 next cycle.
- Reset mid-hold: assert MainReset at 2 s of a press on channel 0 -> all outputs 0 and Debounced=2'b11. Release reset while the button is still held -> PressEvt[0] occurs ~1 s after the new debounce; no spurious ReleaseEvt.
